// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl
//   Shares a single-ported branch predictor between the fetch lookup stream
//   and mispredict updates coming back from execute. Mispredicts are queued
//   in a small FIFO. The queue is replayed on the predictor update path
//   (bp_mispred=1) whenever fetch is idle. When the queue is full, one
//   update is forced and fetch is stalled for that cycle. The prediction
//   returned to fetch is registered, so lookup-to-prediction latency is one
//   cycle.
//
//   Optional feature: define BP_UPD_COALESCE_EN to merge a mispredict whose
//   PC is already queued into that entry (target overwritten in place).
//
// Parameters
//   DEPTH : update FIFO entries (power of 2, >= 2)
//   AW    : address width
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   fe_valid/addr   : fetch lookup request and PC
//   fe_stall        : lookup not serviced this cycle, fetch holds
//   flush           : kill the prediction being captured
//   fe_pred_*       : registered prediction (valid, taken, target)
//   ex_valid/mispred/pc/target : resolved branch from EX
//   ex_ready        : FIFO can accept a push
//   bp_addr/mispred/t_addr/tp_addr : drive the predictor
//   bp_hit/taken/paddr             : predictor lookup result
//   q_count         : FIFO occupancy
module bp_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fe_valid,
  input  logic [AW-1:0]              fe_addr,
  output logic                       fe_stall,
  input  logic                       flush,
  output logic                       fe_pred_valid,
  output logic                       fe_pred_taken,
  output logic [AW-1:0]              fe_pred_addr,
  input  logic                       ex_valid,
  input  logic                       ex_mispred,
  input  logic [AW-1:0]              ex_pc,
  input  logic [AW-1:0]              ex_target,
  output logic                       ex_ready,
  output logic [AW-1:0]              bp_addr,
  output logic                       bp_mispred,
  output logic [AW-1:0]              bp_t_addr,
  output logic [AW-1:0]              bp_tp_addr,
  input  logic                       bp_hit,
  input  logic                       bp_taken,
  input  logic [AW-1:0]              bp_paddr,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    LOOK,
    UPD
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] pc_mem  [DEPTH];
  logic [AW-1:0] tgt_mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next;
  logic          req, append, pop, coalesce;

  // ---------------------------------------------------------------------
  // Push / pop qualification
  // ---------------------------------------------------------------------
  assign req      = ex_valid && ex_mispred;
  assign ex_ready = (count != FULL);
  assign pop      = (state == UPD) && (count != '0);
  assign append   = req && ex_ready && !coalesce;

`ifdef BP_UPD_COALESCE_EN
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] off;
  logic          hit;

  // Search live entries for the incoming PC. The head is excluded when it
  // is leaving this cycle, so such a push appends behind it instead.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    off     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if ((CW'(off) < count) && !(pop && (off == '0)) && (pc_mem[i] == ex_pc)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign coalesce = req && hit;
`else
  assign coalesce = 1'b0;
`endif

  always_comb begin
    count_next = count;
    if (append && !pop)
      count_next = count + CW'(1);
    else if (!append && pop)
      count_next = count - CW'(1);
  end

  // ---------------------------------------------------------------------
  // FIFO storage (contents need no reset; emptiness comes from count)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (append) begin
      pc_mem[tail]  <= ex_pc;
      tgt_mem[tail] <= ex_target;
    end
`ifdef BP_UPD_COALESCE_EN
    if (coalesce)
      tgt_mem[hit_idx] <= ex_target;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (append)
        tail <= tail + PW'(1);
      if (pop)
        head <= head + PW'(1);
      count <= count_next;
    end
  end

  assign q_count    = count;
  assign bp_t_addr  = (count == '0) ? '0 : pc_mem[head];
  assign bp_tp_addr = (count == '0) ? '0 : tgt_mem[head];

  // ---------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= LOOK;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    bp_mispred = 1'b0;
    fe_stall   = 1'b0;
    unique case (state)
      LOOK: begin
        if ((count != '0) && (!fe_valid || (count == FULL)))
          state_next = UPD;
      end
      UPD: begin
        bp_mispred = 1'b1;
        fe_stall   = fe_valid;
        if ((count_next != '0) && !fe_valid)
          state_next = UPD;
        else
          state_next = LOOK;
      end
      default: state_next = LOOK;
    endcase
  end

  assign bp_addr = fe_addr;

  // ---------------------------------------------------------------------
  // Registered prediction back to fetch
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_pred_valid <= 1'b0;
      fe_pred_taken <= 1'b0;
      fe_pred_addr  <= '0;
    end else if ((state == LOOK) && fe_valid && !flush) begin
      fe_pred_valid <= 1'b1;
      fe_pred_taken <= bp_hit && bp_taken;
      fe_pred_addr  <= bp_hit ? bp_paddr : '0;
    end else begin
      fe_pred_valid <= 1'b0;
      fe_pred_taken <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
module tb_bp_update_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fe_valid = 1'b0;
  logic [AW-1:0] fe_addr = '0;
  logic          fe_stall;
  logic          flush = 1'b0;
  logic          fe_pred_valid;
  logic          fe_pred_taken;
  logic [AW-1:0] fe_pred_addr;
  logic          ex_valid = 1'b0;
  logic          ex_mispred = 1'b0;
  logic [AW-1:0] ex_pc = '0;
  logic [AW-1:0] ex_target = '0;
  logic          ex_ready;
  logic [AW-1:0] bp_addr;
  logic          bp_mispred;
  logic [AW-1:0] bp_t_addr;
  logic [AW-1:0] bp_tp_addr;
  logic          bp_hit = 1'b0;
  logic          bp_taken = 1'b0;
  logic [AW-1:0] bp_paddr = '0;
  logic [2:0]    q_count;

  int n_checks = 0;
  int n_fail   = 0;

  bp_update_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .fe_valid(fe_valid), .fe_addr(fe_addr), .fe_stall(fe_stall), .flush(flush),
    .fe_pred_valid(fe_pred_valid), .fe_pred_taken(fe_pred_taken), .fe_pred_addr(fe_pred_addr),
    .ex_valid(ex_valid), .ex_mispred(ex_mispred), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_ready(ex_ready),
    .bp_addr(bp_addr), .bp_mispred(bp_mispred), .bp_t_addr(bp_t_addr), .bp_tp_addr(bp_tp_addr),
    .bp_hit(bp_hit), .bp_taken(bp_taken), .bp_paddr(bp_paddr),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic [AW-1:0] tgt);
    ex_valid   = 1'b1;
    ex_mispred = 1'b1;
    ex_pc      = pc;
    ex_target  = tgt;
  endtask

  task automatic no_push();
    ex_valid   = 1'b0;
    ex_mispred = 1'b0;
  endtask

  initial begin
    // Reset state
    fe_addr = 32'h55;
    tick();
    tick();
    chk("rst_count",    64'(q_count), 64'd0);
    chk("rst_ready",    64'(ex_ready), 64'd1);
    chk("rst_mispred",  64'(bp_mispred), 64'd0);
    chk("rst_stall",    64'(fe_stall), 64'd0);
    chk("rst_t_addr",   64'(bp_t_addr), 64'd0);
    chk("rst_tp_addr",  64'(bp_tp_addr), 64'd0);
    chk("rst_pvalid",   64'(fe_pred_valid), 64'd0);
    chk("rst_ptaken",   64'(fe_pred_taken), 64'd0);
    chk("rst_paddr",    64'(fe_pred_addr), 64'd0);
    chk("rst_bp_addr",  64'(bp_addr), 64'h55);
    rst = 1'b0;
    tick();
    chk("idle_pvalid",  64'(fe_pred_valid), 64'd0);

    // Lookup hit
    fe_valid = 1'b1; fe_addr = 32'h40; bp_hit = 1'b1; bp_taken = 1'b1; bp_paddr = 32'h100;
    #1;
    chk("lk_bp_addr",   64'(bp_addr), 64'h40);
    chk("lk_stall",     64'(fe_stall), 64'd0);
    tick();
    chk("lk_pvalid",    64'(fe_pred_valid), 64'd1);
    chk("lk_ptaken",    64'(fe_pred_taken), 64'd1);
    chk("lk_paddr",     64'(fe_pred_addr), 64'h100);
    // Same lookup with flush
    flush = 1'b1;
    tick();
    chk("fl_pvalid",    64'(fe_pred_valid), 64'd0);
    chk("fl_ptaken",    64'(fe_pred_taken), 64'd0);
    chk("fl_paddr_hold",64'(fe_pred_addr), 64'h100);
    // Lookup miss
    flush = 1'b0; bp_hit = 1'b0;
    tick();
    chk("miss_pvalid",  64'(fe_pred_valid), 64'd1);
    chk("miss_ptaken",  64'(fe_pred_taken), 64'd0);
    chk("miss_paddr",   64'(fe_pred_addr), 64'd0);
    fe_valid = 1'b0;
    tick();
    chk("noreq_pvalid", 64'(fe_pred_valid), 64'd0);

    // Correct prediction is never queued
    ex_valid = 1'b1; ex_mispred = 1'b0; ex_pc = 32'h999; ex_target = 32'h888;
    tick();
    no_push();
    chk("noq_count",    64'(q_count), 64'd0);

    // Idle drain
    push(32'h200, 32'h300);
    tick();
    no_push();
    chk("dr_count1",    64'(q_count), 64'd1);
    chk("dr_t_vis",     64'(bp_t_addr), 64'h200);
    chk("dr_tp_vis",    64'(bp_tp_addr), 64'h300);
    chk("dr_look",      64'(bp_mispred), 64'd0);
    tick();
    chk("dr_mispred",   64'(bp_mispred), 64'd1);
    chk("dr_stall",     64'(fe_stall), 64'd0);
    chk("dr_t_addr",    64'(bp_t_addr), 64'h200);
    chk("dr_tp_addr",   64'(bp_tp_addr), 64'h300);
    tick();
    chk("dr_count0",    64'(q_count), 64'd0);
    chk("dr_back_look", 64'(bp_mispred), 64'd0);
    chk("dr_t_empty",   64'(bp_t_addr), 64'd0);

    // Full FIFO with continuous fetch
    fe_valid = 1'b1; fe_addr = 32'h80;
    push(32'h10, 32'h110); tick();
    push(32'h20, 32'h120); tick();
    push(32'h30, 32'h130); tick();
    push(32'h40, 32'h140); tick();
    chk("fu_count4",    64'(q_count), 64'd4);
    chk("fu_ready0",    64'(ex_ready), 64'd0);
    chk("fu_look",      64'(bp_mispred), 64'd0);
    push(32'h50, 32'h150);             // dropped: FIFO full
    tick();
    no_push();
    chk("fu_drop_cnt",  64'(q_count), 64'd4);
    chk("fu_stall",     64'(fe_stall), 64'd1);
    chk("fu_mispred",   64'(bp_mispred), 64'd1);
    chk("fu_t_addr",    64'(bp_t_addr), 64'h10);
    chk("fu_tp_addr",   64'(bp_tp_addr), 64'h110);
    tick();
    chk("fu_count3",    64'(q_count), 64'd3);
    chk("fu_ready1",    64'(ex_ready), 64'd1);
    chk("fu_stall0",    64'(fe_stall), 64'd0);
    chk("fu_look2",     64'(bp_mispred), 64'd0);
    chk("fu_head2",     64'(bp_t_addr), 64'h20);
    chk("fu_nopred",    64'(fe_pred_valid), 64'd0);

    // Simultaneous push/pop in UPD
    fe_valid = 1'b0;
    tick();
    chk("sp_upd",       64'(bp_mispred), 64'd1);
    chk("sp_cnt3",      64'(q_count), 64'd3);
    chk("sp_head20",    64'(bp_t_addr), 64'h20);
    tick();
    chk("sp_cnt2",      64'(q_count), 64'd2);
    chk("sp_head30",    64'(bp_t_addr), 64'h30);
    push(32'h60, 32'h160);
    tick();
    no_push();
    chk("sp_cnt_keep",  64'(q_count), 64'd2);
    chk("sp_head40",    64'(bp_t_addr), 64'h40);
    chk("sp_tp140",     64'(bp_tp_addr), 64'h140);
    chk("sp_still_upd", 64'(bp_mispred), 64'd1);
    tick();
    chk("sp_cnt1",      64'(q_count), 64'd1);
    chk("sp_head60",    64'(bp_t_addr), 64'h60);
    chk("sp_tp160",     64'(bp_tp_addr), 64'h160);
    tick();
    chk("sp_cnt0",      64'(q_count), 64'd0);
    chk("sp_look",      64'(bp_mispred), 64'd0);

    // Duplicate PC pushes
    fe_valid = 1'b1;
    push(32'h200, 32'h300); tick();
    push(32'h200, 32'h340); tick();
    no_push();
`ifdef BP_UPD_COALESCE_EN
    chk("co_count",     64'(q_count), 64'd1);
`else
    chk("co_count",     64'(q_count), 64'd2);
`endif
    fe_valid = 1'b0;
    tick();
    chk("co_upd",       64'(bp_mispred), 64'd1);
    chk("co_t_addr",    64'(bp_t_addr), 64'h200);
`ifdef BP_UPD_COALESCE_EN
    chk("co_tp_first",  64'(bp_tp_addr), 64'h340);
    tick();
    chk("co_cnt0",      64'(q_count), 64'd0);
    chk("co_look",      64'(bp_mispred), 64'd0);
`else
    chk("co_tp_first",  64'(bp_tp_addr), 64'h300);
    tick();
    chk("co_cnt1",      64'(q_count), 64'd1);
    chk("co_tp_second", 64'(bp_tp_addr), 64'h340);
    chk("co_upd2",      64'(bp_mispred), 64'd1);
    tick();
    chk("co_cnt0",      64'(q_count), 64'd0);
    chk("co_look",      64'(bp_mispred), 64'd0);
`endif

    // Reset asserted mid-UPD with three queued entries
    fe_valid = 1'b1;
    push(32'h11, 32'h111); tick();
    push(32'h22, 32'h122); tick();
    push(32'h33, 32'h133); tick();
    no_push();
    fe_valid = 1'b0;
    tick();
    chk("mr_upd",       64'(bp_mispred), 64'd1);
    chk("mr_cnt3",      64'(q_count), 64'd3);
    rst = 1'b1;
    #1;
    chk("mr_mispred",   64'(bp_mispred), 64'd0);
    chk("mr_count",     64'(q_count), 64'd0);
    chk("mr_ready",     64'(ex_ready), 64'd1);
    chk("mr_pvalid",    64'(fe_pred_valid), 64'd0);
    chk("mr_t_addr",    64'(bp_t_addr), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_post_cnt",  64'(q_count), 64'd0);
    chk("mr_post_look", 64'(bp_mispred), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
